// File: rtl/u_data_mem_ctrl.sv
// Word-organised data memory controller for byte, halfword and word loads and stores.
// Each access takes a fixed number of wait states, with a fault check and a one-cycle done/err pulse.
module u_data_mem_ctrl #(
    parameter int unsigned DEPTH_WORDS = 2048,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        i_sys_clock,
    input  logic        i_sys_reset,
    input  logic        i_u_data_mem_ctrl_req,
    input  logic        i_u_data_mem_ctrl_wr,
    input  logic [1:0]  i_u_data_mem_ctrl_size,
    input  logic        i_u_data_mem_ctrl_unsigned,
    input  logic [31:0] i_u_data_mem_ctrl_addr,
    input  logic [31:0] i_u_data_mem_ctrl_wdata,
    output logic        o_u_data_mem_ctrl_busy,
    output logic        o_u_data_mem_ctrl_done,
    output logic [31:0] o_u_data_mem_ctrl_rdata,
    output logic        o_u_data_mem_ctrl_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        accept;
    logic        commit;
    logic [3:0]  cnt;

    logic        cap_wr;
    logic [1:0]  cap_size;
    logic        cap_unsigned;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;

    logic          fault;
    logic [AW-1:0] word_idx;
    logic [31:0]   cur_word;
    logic [31:0]   store_word;
    logic [31:0]   load_val;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;

    logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

    always_ff @(posedge i_sys_clock) begin
        if (i_sys_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (i_u_data_mem_ctrl_req) begin
                    accept     = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    commit     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign o_u_data_mem_ctrl_busy = (state == ACCESS);

    always_ff @(posedge i_sys_clock) begin
        if (accept && !i_sys_reset) begin
            cap_wr       <= i_u_data_mem_ctrl_wr;
            cap_size     <= i_u_data_mem_ctrl_size;
            cap_unsigned <= i_u_data_mem_ctrl_unsigned;
            cap_addr     <= i_u_data_mem_ctrl_addr;
            cap_wdata    <= i_u_data_mem_ctrl_wdata;
        end
    end

    always_ff @(posedge i_sys_clock) begin
        if (i_sys_reset) begin
            cnt                     <= '0;
            o_u_data_mem_ctrl_done  <= 1'b0;
            o_u_data_mem_ctrl_err   <= 1'b0;
            o_u_data_mem_ctrl_rdata <= '0;
        end else begin
            o_u_data_mem_ctrl_done <= commit;
            o_u_data_mem_ctrl_err  <= commit && fault;
            if (accept) begin
                cnt <= 4'(WAIT_STATES);
            end else if (state == ACCESS && cnt != '0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit && !cap_wr) begin
                o_u_data_mem_ctrl_rdata <= fault ? '0 : load_val;
            end
        end
    end

    // Alignment faults depend on size; the range check covers every address bit above the word index.
    always_comb begin
        fault = 1'b0;
        case (cap_size)
            2'b00:   fault = 1'b0;
            2'b01:   fault = cap_addr[0];
            2'b10:   fault = |cap_addr[1:0];
            default: fault = 1'b1;
        endcase
        if (|cap_addr[31:AW+2]) begin
            fault = 1'b1;
        end
    end

    assign word_idx = cap_addr[AW+1:2];
    assign cur_word = mem[word_idx];

    always_comb begin
        byte_sel = cur_word[7:0];
        case (cap_addr[1:0])
            2'b00:   byte_sel = cur_word[7:0];
            2'b01:   byte_sel = cur_word[15:8];
            2'b10:   byte_sel = cur_word[23:16];
            default: byte_sel = cur_word[31:24];
        endcase
        half_sel = cap_addr[1] ? cur_word[31:16] : cur_word[15:0];

        load_val = cur_word;
        case (cap_size)
            2'b00:   load_val = cap_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_val = cap_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_val = cur_word;
        endcase
    end

    always_comb begin
        store_word = cur_word;
        case (cap_size)
            2'b00:   store_word[{cap_addr[1:0], 3'b000} +: 8] = cap_wdata[7:0];
            2'b01:   store_word[{cap_addr[1], 4'b0000} +: 16] = cap_wdata[15:0];
            default: store_word = cap_wdata;
        endcase
    end

    // Write is a read-modify-write of the whole word; reset at the commit edge cancels it.
    always_ff @(posedge i_sys_clock) begin
        if (commit && cap_wr && !fault && !i_sys_reset) begin
            mem[word_idx] <= store_word;
        end
    end

endmodule

// File: doc/u_data_mem_ctrl.md
U_DATA_MEM_CTRL -- requirements
Module: u_data_mem_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 2048, giving the number of 32-bit words; it SHALL be a power of two in the range 256..65536.
REQ-002 The block SHALL have parameter WAIT_STATES, default 0, giving the extra wait cycles per access, in the range 0..15.
REQ-003 The block SHALL have port i_sys_clock, input, width 1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port i_sys_reset, input, width 1: reset, synchronous and active-high.
REQ-005 The block SHALL have port i_u_data_mem_ctrl_req, input, width 1: access request; sampled only when not busy.
REQ-006 The block SHALL have port i_u_data_mem_ctrl_wr, input, width 1: 1 = store, 0 = load.
REQ-007 The block SHALL have port i_u_data_mem_ctrl_size, input, width 2: 00 = byte, 01 = halfword, 10 = word, 11 = reserved.
REQ-008 The block SHALL have port i_u_data_mem_ctrl_unsigned, input, width 1: 1 = zero-extend load data, 0 = sign-extend load data.
REQ-009 The block SHALL have port i_u_data_mem_ctrl_addr, input, width 32: byte address.
REQ-010 The block SHALL have port i_u_data_mem_ctrl_wdata, input, width 32: store data, right-aligned.
REQ-011 The block SHALL have port o_u_data_mem_ctrl_busy, output, width 1: access in flight; the pipeline stalls on it.
REQ-012 The block SHALL have port o_u_data_mem_ctrl_done, output, width 1: one-cycle pulse on completion of any access.
REQ-013 The block SHALL have port o_u_data_mem_ctrl_rdata, output, width 32: registered load result.
REQ-014 The block SHALL have port o_u_data_mem_ctrl_err, output, width 1: one-cycle pulse, coincident with done, when the completed access faulted.

Function
REQ-015 The storage SHALL be DEPTH_WORDS x 32 bits, little-endian: byte 0 = [7:0], byte 3 = [31:24].
REQ-016 The word index SHALL be addr[AW+1:2], where AW = log2(DEPTH_WORDS).
REQ-017 The FSM SHALL have states IDLE and ACCESS; o_u_data_mem_ctrl_busy SHALL equal (state == ACCESS), combinationally.
REQ-018 In IDLE with req=1, the rising edge SHALL:
- capture wr, size, unsigned, addr and wdata;
- load the wait counter with WAIT_STATES;
- enter ACCESS.
REQ-019 In IDLE with req=0, the state SHALL stay IDLE.
REQ-020 In ACCESS with counter != 0, each edge SHALL decrement the counter; inputs SHALL be ignored.
REQ-021 In ACCESS with counter == 0, the edge SHALL:
- commit the access;
- pulse done for the following cycle;
- return to IDLE.
REQ-022 Latency SHALL be: request accepted at edge E0, done high in the cycle after edge E0+WAIT_STATES+1.
REQ-023 Back-to-back operation: a new request SHALL be acceptable at the same edge at which done is high, so a new access can start every WAIT_STATES+2 cycles.
REQ-024 A fault SHALL be raised by any of:
- size = 11;
- halfword with addr[0] = 1;
- word with addr[1:0] != 00;
- addr[31:AW+2] != 0 (out of range).
REQ-025 A faulting access SHALL pulse err together with done.
REQ-026 A faulting store SHALL leave memory unchanged.
REQ-027 A faulting load SHALL set rdata to 0.
REQ-028 Store, byte: wdata[7:0] SHALL be written to the lane selected by addr[1:0]; other lanes unchanged.
REQ-029 Store, halfword: wdata[15:0] SHALL be written to [15:0] when addr[1]=0, or to [31:16] when addr[1]=1.
REQ-030 Store, word: the full wdata SHALL be written.
REQ-031 Load: the selected byte or halfword SHALL be right-aligned and extended per unsigned, then registered into rdata at the commit edge.
REQ-032 rdata SHALL hold its value until the next load commits; stores SHALL NOT change rdata.
REQ-033 Loads SHALL read the memory contents at the commit edge, so a store completed earlier is always visible.
REQ-034 Memory contents SHALL be zero at time 0 and SHALL NOT be affected by reset.

Reset
REQ-035 When i_sys_reset=1 at an edge, the block SHALL set state = IDLE, counter = 0, done = 0, err = 0, rdata = 0; busy therefore = 0.
REQ-036 Reset SHALL take priority over req.
REQ-037 Reset during ACCESS SHALL abandon the access: no memory write, no done pulse.

Verification
REQ-038 WAIT_STATES=0: store word 0xDEADBEEF at 0x10, then load word at 0x10 -> busy high 1 cycle per access, done 2 cycles after each accept edge, rdata = 0xDEADBEEF.
REQ-039 After REQ-038: store byte 0x5A at 0x13, then load signed byte at 0x13 -> rdata = 0x0000005A; load word at 0x10 -> rdata = 0x5AADBEEF; load signed half at 0x12 -> rdata = 0x00005AAD.
REQ-040 Store byte 0x80 at 0x20, then load byte at 0x20 -> rdata = 0xFFFFFF80 when signed, 0x00000080 when unsigned.
REQ-041 Load word at 0x22, store half at 0x21, size=11, and addr = DEPTH_WORDS*4 -> err and done pulse for each; memory unchanged; load rdata = 0.
REQ-042 WAIT_STATES=3: load accepted at E0 -> busy for 4 cycles, done in cycle after E4; req toggling during busy ignored; reset asserted at E2 of a store -> no done pulse, target word unchanged.
